// File: rtl/cu_fsm.sv
// cu_fsm: multicycle control FSM for the OTTER RV32I core.
// Sequences FETCH/EXEC/WB/INTR and drives the commit strobes.
//
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   INTR                  async external interrupt request (level)
//   MIE                   machine interrupt enable from CSR file
//   IR_OPCODE, IR_FUNCT   ir[6:0], ir[14:12]
//   RST                   sync reset to PC and reg file
//   PC_WRITE, REG_WRITE   PC load / register file write enables
//   MEM_RDEN1, MEM_RDEN2  instruction / data port read enables
//   MEM_WE2               data port write enable
//   CSR_WE                CSR write (csrrw)
//   INT_TAKEN             interrupt entry (PC<=MTVEC, MEPC<=PC)
//   MRET_EXEC             mret (PC<=MEPC)
//   STATE                 current state encoding (debug)
module cu_fsm #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       INTR,
   input  logic       MIE,
   input  logic [6:0] IR_OPCODE,
   input  logic [2:0] IR_FUNCT,
   output logic       RST,
   output logic       PC_WRITE,
   output logic       REG_WRITE,
   output logic       MEM_RDEN1,
   output logic       MEM_RDEN2,
   output logic       MEM_WE2,
   output logic       CSR_WE,
   output logic       INT_TAKEN,
   output logic       MRET_EXEC,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F_MRET  = 3'b000;
   localparam logic [2:0] F_CSRRW = 3'b001;

   state_t                 state_q;
   state_t                 state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   pend_q;
   logic                   edge_det;
   logic                   int_go;
   logic                   is_load;

   // Rising edge seen at the synchronizer output.
   assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign int_go   = pend_q & MIE;
   assign is_load  = (IR_OPCODE == OPC_LOAD);
   assign STATE    = state_q;

   always_comb begin
      state_d = ST_INIT;
      case (state_q)
         ST_INIT:  state_d = ST_FETCH;
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (is_load)     state_d = ST_WB;
            else if (int_go) state_d = ST_INTR;
            else             state_d = ST_FETCH;
         end
         ST_WB:    state_d = int_go ? ST_INTR : ST_FETCH;
         ST_INTR:  state_d = ST_FETCH;
         default:  state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_INIT;
         sync_q  <= '0;
         hist_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], INTR};
         hist_q  <= sync_q[SYNC_STAGES-1];
         // A new edge beats the clear; MIE=0 freezes the request.
         if (edge_det)
            pend_q <= 1'b1;
         else if (state_q == ST_INTR && MIE)
            pend_q <= 1'b0;
      end
   end

   // Outputs decode straight from state so an async reset
   // drops every commit strobe in the same instant.
   always_comb begin
      RST       = 1'b0;
      PC_WRITE  = 1'b0;
      REG_WRITE = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      CSR_WE    = 1'b0;
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
      case (state_q)
         ST_INIT:  RST = 1'b1;
         ST_FETCH: MEM_RDEN1 = 1'b1;
         ST_EXEC: begin
            case (IR_OPCODE)
               OPC_LOAD: MEM_RDEN2 = 1'b1;
               OPC_STORE: begin
                  MEM_WE2  = 1'b1;
                  PC_WRITE = 1'b1;
               end
               OPC_BRANCH: PC_WRITE = 1'b1;
               OPC_OP, OPC_OP_IMM, OPC_LUI,
               OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                  REG_WRITE = 1'b1;
                  PC_WRITE  = 1'b1;
               end
               OPC_SYSTEM: begin
                  PC_WRITE = 1'b1;
                  if (IR_FUNCT == F_CSRRW) begin
                     CSR_WE    = 1'b1;
                     REG_WRITE = 1'b1;
                  end else if (IR_FUNCT == F_MRET) begin
                     MRET_EXEC = 1'b1;
                  end
               end
               // Unknown opcodes retire as a nop.
               default: PC_WRITE = 1'b1;
            endcase
         end
         ST_WB: begin
            REG_WRITE = 1'b1;
            PC_WRITE  = 1'b1;
         end
         ST_INTR: begin
            INT_TAKEN = 1'b1;
            PC_WRITE  = 1'b1;
         end
         default: RST = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: randomized self-checking bench for cu_fsm.
// Compares every cycle against an instruction-level model.
module tb_cu_fsm;

   localparam int SS = 2;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] OPR    = 7'b0110011;
   localparam logic [6:0] OPI    = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYS    = 7'b1110011;

   logic       CLK;
   logic       RST_N;
   logic       INTR;
   logic       MIE;
   logic [6:0] IR_OPCODE;
   logic [2:0] IR_FUNCT;
   logic       RST;
   logic       PC_WRITE;
   logic       REG_WRITE;
   logic       MEM_RDEN1;
   logic       MEM_RDEN2;
   logic       MEM_WE2;
   logic       CSR_WE;
   logic       INT_TAKEN;
   logic       MRET_EXEC;
   logic [2:0] STATE;

   cu_fsm #(.SYNC_STAGES(SS)) dut (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .MIE(MIE),
      .IR_OPCODE(IR_OPCODE), .IR_FUNCT(IR_FUNCT),
      .RST(RST), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
      .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2),
      .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE),
      .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC),
      .STATE(STATE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Instruction-level model state.
   int         exp_st;
   bit         pend;
   bit         samp[$];
   int         visits;
   int         cyc;
   int         seen4;
   bit         rst_v;
   bit         intr_v;
   bit         mie_v;
   logic [6:0] next_op;
   logic [2:0] next_f;

   // {RST,PC_WRITE,REG_WRITE,RDEN1,RDEN2,WE2,CSR_WE,INT_TAKEN,MRET}
   function automatic logic [8:0] exp_out(int st, logic [6:0] op,
                                          logic [2:0] f);
      logic [8:0] v;
      v = '0;
      case (st)
         0: v[8] = 1'b1;
         1: v[5] = 1'b1;
         2: begin
            if (op == LOAD) begin
               v[4] = 1'b1;
            end else begin
               v[7] = 1'b1;
               if (op == STORE) v[3] = 1'b1;
               else if (op inside {OPR, OPI, LUI, AUIPC, JAL, JALR})
                  v[6] = 1'b1;
               else if (op == SYS && f == 3'd1) begin
                  v[6] = 1'b1;
                  v[2] = 1'b1;
               end else if (op == SYS && f == 3'd0)
                  v[0] = 1'b1;
            end
         end
         3: v[7:6] = 2'b11;
         4: begin
            v[7] = 1'b1;
            v[1] = 1'b1;
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   // INTR level sampled k edges ago (0 before/through reset).
   function automatic bit s_at(int k);
      if (k >= samp.size()) return 1'b0;
      return samp[samp.size()-1-k];
   endfunction

   task automatic step();
      bit edg;
      int fin;
      int nst;
      if (!rst_v) begin
         exp_st = 0;
         pend   = 1'b0;
         samp.delete();
         return;
      end
      samp.push_back(intr_v);
      if (samp.size() > 16) void'(samp.pop_front());
      edg = s_at(SS) & ~s_at(SS+1);
      fin = (pend && mie_v) ? 4 : 1;
      case (exp_st)
         0: nst = 1;
         1: nst = 2;
         2: nst = (IR_OPCODE == LOAD) ? 3 : fin;
         3: nst = fin;
         4: nst = 1;
         default: nst = 0;
      endcase
      if (edg) pend = 1'b1;
      else if (exp_st == 4 && mie_v) pend = 1'b0;
      exp_st = nst;
   endtask

   task automatic cycle();
      logic [8:0] dv;
      @(negedge CLK);
      dv = {RST, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
            MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC};
      check("state", 32'(STATE), 32'(exp_st));
      check("outs", 32'(dv),
            32'(exp_out(exp_st, IR_OPCODE, IR_FUNCT)));
      check("rw_we", 32'(REG_WRITE & MEM_WE2), 0);
      cyc++;
      if (STATE == 3'd4) begin
         visits++;
         if (seen4 < 0) seen4 = cyc;
      end
      RST_N = rst_v;
      INTR  = intr_v;
      MIE   = mie_v;
      if (exp_st == 1) begin
         IR_OPCODE = next_op;
         IR_FUNCT  = next_f;
      end
      @(posedge CLK);
      step();
   endtask

   logic [6:0] ops [12];
   int         v0;
   int         c0;

   initial begin
      ops = '{LOAD, STORE, BRANCH, OPR, OPI, LUI, AUIPC, JAL,
              JALR, SYS, SYS, OPR};
      RST_N = 1'b0;
      INTR = 1'b0;
      MIE = 1'b0;
      IR_OPCODE = OPR;
      IR_FUNCT = 3'd0;
      rst_v = 1'b0;
      intr_v = 1'b0;
      mie_v = 1'b0;
      next_op = OPR;
      next_f = 3'd0;
      exp_st = 0;
      pend = 1'b0;
      visits = 0;
      cyc = 0;
      seen4 = -1;

      #1;
      check("rst_state", 32'(STATE), 0);
      check("rst_rst", 32'(RST), 1);
      check("rst_pcw", 32'(PC_WRITE), 0);

      // ir=0x00208033 (add) after reset release
      repeat (2) cycle();
      rst_v = 1'b1;
      repeat (12) cycle();

      // load / store / branch / csrrw
      next_op = LOAD;   repeat (9) cycle();
      next_op = STORE;  repeat (8) cycle();
      next_op = BRANCH; repeat (8) cycle();
      next_op = SYS; next_f = 3'd1; repeat (8) cycle();
      next_op = OPR; next_f = 3'd0;

      // interrupt during an OP EXEC, MIE=1
      mie_v = 1'b1;
      repeat (4) cycle();
      for (int i = 0; i < 4 && exp_st != 2; i++) cycle();
      v0 = visits;
      seen4 = -1;
      intr_v = 1'b1;
      cycle();
      c0 = cyc;
      cycle();
      cycle();
      intr_v = 1'b0;
      repeat (10) cycle();
      check("int_once", 32'(visits - v0), 1);
      check("int_lat", 32'(seen4 > 0 && (seen4 - c0) <= SS + 4), 1);

      // MIE=0: two pulses, no entry; MIE=1 later: one entry
      mie_v = 1'b0;
      v0 = visits;
      intr_v = 1'b1; repeat (2) cycle();
      intr_v = 1'b0; repeat (2) cycle();
      intr_v = 1'b1; repeat (2) cycle();
      intr_v = 1'b0; repeat (8) cycle();
      check("mie0_none", 32'(visits - v0), 0);
      mie_v = 1'b1;
      repeat (8) cycle();
      check("late_once", 32'(visits - v0), 1);

      // mret with a pending interrupt goes straight to INTR
      mie_v = 1'b0;
      intr_v = 1'b1; repeat (2) cycle();
      intr_v = 1'b0; repeat (5) cycle();
      next_op = SYS; next_f = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (exp_st == 2 && IR_OPCODE == SYS && IR_FUNCT == 3'd0)
            break;
         cycle();
      end
      #1 check("mret_exec", 32'(MRET_EXEC), 1);
      mie_v = 1'b1;
      next_op = OPR;
      cycle();
      #1 check("mret_intr", 32'(STATE), 4);
      repeat (4) cycle();

      // randomized traffic
      repeat (400) begin
         if ($urandom_range(0, 5) == 0) intr_v = ~intr_v;
         if ($urandom_range(0, 19) == 0) mie_v = ~mie_v;
         if ($urandom_range(0, 7) == 0) next_op = 7'($urandom);
         else next_op = ops[$urandom_range(0, 11)];
         next_f = 3'($urandom_range(0, 3));
         cycle();
      end

      // async reset in the middle of WB clears pending
      mie_v = 1'b0;
      intr_v = 1'b1; repeat (2) cycle();
      intr_v = 1'b0; repeat (6) cycle();
      next_op = LOAD;
      for (int i = 0; i < 8 && exp_st != 3; i++) cycle();
      #3;
      rst_v = 1'b0;
      RST_N = 1'b0;
      #1;
      check("arst_state", 32'(STATE), 0);
      check("arst_rw", 32'(REG_WRITE), 0);
      check("arst_rst", 32'(RST), 1);
      exp_st = 0;
      pend = 1'b0;
      samp.delete();
      repeat (2) cycle();
      rst_v = 1'b1;
      mie_v = 1'b1;
      next_op = OPR;
      v0 = visits;
      repeat (12) cycle();
      check("arst_noint", 32'(visits - v0), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
